lc3b_mem_sequencer: RTL and testbench



---
 rtl/lc3b_mem_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_lc3b_mem_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_sequencer.sv
// lc3b_mem_sequencer: one-request-at-a-time memory access engine (word/byte, direct/indirect).
// Optional: define LC3B_MEMSEQ_TIMEOUT_EN to abort accesses after TIMEOUT_CYC wait cycles.
module lc3b_mem_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_byte,
  input  logic                req_indirect,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int LANES = DATA_W / 8;
  localparam int LW    = $clog2(LANES);

  if (DATA_W < 16 || DATA_W % 8 != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("lc3b_mem_sequencer: bad DATA_W or TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {
    IDLE, PTR, ACC_RD, ACC_WR, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                write_q, write_d;
  logic                byte_q, byte_d;
  logic                err_q, err_d;
  logic                tmo;
  logic [ADDR_W-1:0]   ptr;
  logic [LW-1:0]       lane;

  assign ptr  = ADDR_W'(mem_rdata);
  assign lane = addr_q[LW-1:0];

  function automatic logic misal(input logic [ADDR_W-1:0] a,
                                 input logic b);
    return !b && (a[LW-1:0] != '0);
  endfunction

`ifdef LC3B_MEMSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          waiting;

  assign waiting = (state_q == PTR) || (state_q == ACC_RD) ||
                   (state_q == ACC_WR);
  assign tmo = waiting && !mem_resp &&
               (wait_q == TW'(TIMEOUT_CYC - 1));

  // Wait counter restarts whenever a strobe state is (re)entered.
  always_comb begin
    wait_d = '0;
    if (waiting && state_d == state_q && !mem_resp)
      wait_d = wait_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next-state and request/response capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    byte_d  = byte_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          byte_d  = req_byte;
          err_d   = 1'b0;
          if (misal(req_addr, req_byte)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (req_indirect) state_d = PTR;
          else if (req_write)        state_d = ACC_WR;
          else                       state_d = ACC_RD;
        end
      end
      PTR: begin
        if (mem_resp) begin
          addr_d = ptr;
          if (misal(ptr, byte_q)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (write_q) state_d = ACC_WR;
          else                  state_d = ACC_RD;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      ACC_RD: begin
        if (mem_resp) begin
          state_d = DONE;
          if (byte_q)
            rdata_d = DATA_W'(mem_rdata[8*int'(lane) +: 8]);
          else
            rdata_d = mem_rdata;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      ACC_WR: begin
        if (mem_resp) begin
          state_d = DONE;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
    end
  end

  // Memory port and response decoded purely from registered state.
  always_comb begin
    req_ready       = (state_q == IDLE);
    resp_valid      = (state_q == DONE);
    resp_err        = (state_q == DONE) && err_q;
    resp_rdata      = rdata_q;
    mem_address     = addr_q;
    mem_read        = (state_q == PTR) || (state_q == ACC_RD);
    mem_write       = (state_q == ACC_WR);
    mem_byte_enable = '1;
    if (byte_q && (state_q == ACC_RD || state_q == ACC_WR))
      mem_byte_enable = LANES'(1) << lane;
    mem_wdata = byte_q ? {LANES{wdata_q[7:0]}} : wdata_q;
  end

endmodule

// File: tb/tb_lc3b_mem_sequencer.sv
// tb_lc3b_mem_sequencer: directed vectors with a response scoreboard.
// Memory model answers strobes after a programmable number of wait cycles.
module tb_lc3b_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_indirect = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  lc3b_mem_sequencer #(
    .DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte),
    .req_indirect(req_indirect), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
  } acc_t;

  exp_t        sb[$];
  acc_t        log_q[$];
  logic [15:0] memw[int];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 0;
  int          wcnt = 0;
  int          strobe_cyc = 0;
  bit          hang = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: answers a strobe after lat wait cycles.
  always @(negedge clk) begin
    mem_resp = 1'b0;
    if (mem_read || mem_write) begin
      chk("strobe_excl", 32'(mem_read & mem_write), 0);
      strobe_cyc++;
      if (!hang && wcnt == lat) begin
        int a;
        a = int'({mem_address[15:1], 1'b0});
        mem_resp = 1'b1;
        mem_rdata = memw.exists(a) ? memw[a] : 16'h0000;
        log_q.push_back('{mem_write, mem_address,
                          mem_byte_enable, mem_wdata});
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input bit wr, input bit bt, input bit ind,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] erd, input bit eerr,
                       input int lcy);
    @(negedge clk);
    req_write = wr;
    req_byte = bt;
    req_indirect = ind;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    chk("req_ready_idle", 32'(req_ready), 1);
    sb.push_back('{erd, eerr, cyc + lcy});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk({nm, "_drain"}, sb.size(), 0);
  endtask

  task automatic clr();
    log_q.delete();
    strobe_cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_be", 32'(mem_byte_enable), 2'b11);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 1'b0;

    // word load, 3 wait cycles
    clr();
    lat = 3;
    memw[16'h0040] = 16'hBEEF;
    issue(0, 0, 0, 16'h0040, 16'h0, 16'hBEEF, 0, 5);
    drain("wload");
    lat = 0;
    chk("wload_strobes", strobe_cyc, 4);
    chk("wload_nacc", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("wload_be", 32'(log_q[0].be), 2'b11);
      chk("wload_addr", log_q[0].addr, 16'h0040);
      chk("wload_wr", 32'(log_q[0].wr), 0);
    end

    // byte load, upper lane, zero wait
    clr();
    memw[16'h0040] = 16'h12AB;
    issue(0, 1, 0, 16'h0041, 16'h0, 16'h0012, 0, 2);
    drain("bload");
    chk("bload_nacc", log_q.size(), 1);
    if (log_q.size() == 1)
      chk("bload_be", 32'(log_q[0].be), 2'b10);

    // byte store, lower lane
    clr();
    issue(1, 1, 0, 16'h0040, 16'h00C3, 16'h0012, 0, 2);
    drain("bstore");
    chk("bstore_nacc", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("bstore_wr", 32'(log_q[0].wr), 1);
      chk("bstore_be", 32'(log_q[0].be), 2'b01);
      chk("bstore_wdata", log_q[0].wd, 16'hC3C3);
    end

    // indirect word store through pointer at 0x0100
    clr();
    memw[16'h0100] = 16'h3000;
    issue(1, 0, 1, 16'h0100, 16'h5A5A, 16'h0012, 0, 3);
    drain("istore");
    chk("istore_nacc", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("istore_p_wr", 32'(log_q[0].wr), 0);
      chk("istore_p_addr", log_q[0].addr, 16'h0100);
      chk("istore_p_be", 32'(log_q[0].be), 2'b11);
      chk("istore_a_wr", 32'(log_q[1].wr), 1);
      chk("istore_a_addr", log_q[1].addr, 16'h3000);
      chk("istore_a_wdata", log_q[1].wd, 16'h5A5A);
      chk("istore_a_be", 32'(log_q[1].be), 2'b11);
    end

    // misaligned word load: error, no strobe
    clr();
    issue(0, 0, 0, 16'h0003, 16'h0, 16'h0012, 1, 1);
    drain("misal");
    chk("misal_strobes", strobe_cyc, 0);

    // req_valid held high across a busy access
    clr();
    memw[16'h0040] = 16'h1234;
    @(negedge clk);
    req_write = 0;
    req_byte = 0;
    req_indirect = 0;
    req_addr = 16'h0040;
    req_valid = 1'b1;
    sb.push_back('{16'h1234, 1'b0, cyc + 2});
    sb.push_back('{16'h1234, 1'b0, cyc + 5});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("hold_ready", 32'(req_ready), (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_ready_busy", 32'(req_ready), 0);
    drain("hold");
    chk("hold_nacc", log_q.size(), 2);

    // reset during an ACC_RD wait
    clr();
    hang = 1'b1;
    @(negedge clk);
    req_addr = 16'h0040;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_rd_before", 32'(mem_read), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_rd_after", 32'(mem_read), 0);
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_resp", 32'(resp_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    hang = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_rdata", resp_rdata, 0);
    chk("abort_ready_idle", 32'(req_ready), 1);

`ifdef LC3B_MEMSEQ_TIMEOUT_EN
    // no mem_resp: timeout after 4 strobe cycles
    clr();
    hang = 1'b1;
    issue(0, 0, 0, 16'h0040, 16'h0, 16'h0000, 1, 5);
    drain("tmo");
    hang = 1'b0;
    chk("tmo_strobes", strobe_cyc, 4);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
